rst_seq_ctrl: RTL

- Consumes the `clk`/`locked` pair produced by the system clock generator.
- Qualifies `locked` for stability, then releases reset to downstream domains in a fixed order: peripherals first, then core.
- Re-asserts reset on loss of lock or on a software reset request, and counts lock-loss events.
- Sits between the clock generator and all SoC reset consumers.

---
 rtl/rst_seq_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: qualifies clock-generator lock, then releases peripheral and core resets in order.
// Optional lock-wait watchdog is built when RST_SEQ_LOCK_WDOG_EN is defined.
module rst_seq_ctrl #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 16,
  parameter int unsigned SEQ_GAP            = 4,
  parameter int unsigned SW_RST_CYCLES      = 8,
  parameter int unsigned CNT_W              = 8,
  parameter int unsigned WDOG_CYCLES        = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             locked,
  input  logic             sw_rst_req,
  output logic             rstn_periph,
  output logic             rstn_core,
  output logic             rst_busy,
  output logic [CNT_W-1:0] lock_lost_cnt,
  output logic             lock_timeout
);

  localparam int unsigned STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int unsigned GAP_W  = (SEQ_GAP > 1) ? $clog2(SEQ_GAP) : 1;
  localparam int unsigned SW_W   = (SW_RST_CYCLES > 1) ? $clog2(SW_RST_CYCLES) : 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SEQ_GAP - 1);
  localparam logic [SW_W-1:0]   SW_LAST   = SW_W'(SW_RST_CYCLES - 1);

  if (SYNC_STAGES < 2 || LOCK_STABLE_CYCLES < 1 || SEQ_GAP < 1 ||
      SW_RST_CYCLES < 1 || CNT_W < 1 || WDOG_CYCLES < 1) begin : g_param_check
    $error("rst_seq_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK,
    GAP,
    RUN,
    SW_RST
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                locked_s;
  logic [STAB_W-1:0]   stab_q, stab_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [SW_W-1:0]     sw_q, sw_d;
  logic                periph_q, periph_d;
  logic                core_q, core_d;
  logic                busy_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    stab_d   = stab_q;
    gap_d    = gap_q;
    sw_d     = sw_q;
    periph_d = periph_q;
    core_d   = core_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        periph_d = 1'b0;
        core_d   = 1'b0;
        if (!locked_s) begin
          stab_d = '0;
        end else if (stab_q == STAB_LAST) begin
          periph_d = 1'b1;
          gap_d    = '0;
          state_d  = GAP;
        end else begin
          stab_d = stab_q + STAB_W'(1);
        end
      end
      GAP: begin
        if (!locked_s) begin
          periph_d = 1'b0;
          core_d   = 1'b0;
          stab_d   = '0;
          gap_d    = '0;
          state_d  = WAIT_LOCK;
        end else if (gap_q == GAP_LAST) begin
          core_d  = 1'b1;
          state_d = RUN;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      RUN: begin
        // Lock loss takes priority over a coincident software request.
        if (!locked_s) begin
          periph_d = 1'b0;
          core_d   = 1'b0;
          stab_d   = '0;
          state_d  = WAIT_LOCK;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (sw_rst_req) begin
          periph_d = 1'b0;
          core_d   = 1'b0;
          sw_d     = '0;
          state_d  = SW_RST;
        end
      end
      SW_RST: begin
        periph_d = 1'b0;
        core_d   = 1'b0;
        if (!locked_s || sw_q == SW_LAST) begin
          stab_d  = '0;
          state_d = WAIT_LOCK;
        end else begin
          sw_d = sw_q + SW_W'(1);
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q   <= '0;
      state_q  <= WAIT_LOCK;
      stab_q   <= '0;
      gap_q    <= '0;
      sw_q     <= '0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      busy_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], locked};
      state_q  <= state_d;
      stab_q   <= stab_d;
      gap_q    <= gap_d;
      sw_q     <= sw_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      busy_q   <= ~core_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rstn_periph   = periph_q;
  assign rstn_core     = core_q;
  assign rst_busy      = busy_q;
  assign lock_lost_cnt = cnt_q;

`ifdef RST_SEQ_LOCK_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;

  // Count restarts on every entry into WAIT_LOCK and saturates at the limit.
  always_comb begin
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    if (state_d == WAIT_LOCK && state_q != WAIT_LOCK) begin
      wdog_d = '0;
    end else if (state_q == WAIT_LOCK && wdog_q != WDOG_W'(WDOG_CYCLES)) begin
      wdog_d = wdog_q + WDOG_W'(1);
      if (wdog_d == WDOG_W'(WDOG_CYCLES)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign lock_timeout = timeout_q;
`else
  assign lock_timeout = 1'b0;
`endif

endmodule
